irq_sequencer: RTL

- Interrupt sequencer for the 5-stage pipeline. Latches multiple interrupt sources as pending, applies a mask, and picks one by fixed priority.
- Drives the pipeline interrupt-entry controls: Int_flush, Int_sel, PC_Int and returnadress. Sits beside the CSR logic at M-stage timing.
- Owns entry and return sequencing: captures the return PC and blocks nesting until returnM.

---
 rtl/irq_seq_pkg.sv | 21 ++
 rtl/irq_prio_enc.sv | 25 ++
 rtl/irq_sequencer.sv | 135 +++++++++++++
 3 files changed

// File: rtl/irq_seq_pkg.sv
// Shared types and constants for the interrupt sequencer: FSM state encoding,
// default vector layout and the source-index width helper.
package irq_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FLUSH,
        VECTOR,
        HANDLER,
        RETURN
    } irqState_e;

    localparam logic [31:0] DEFAULT_VEC_BASE   = 32'h0000_0100;
    localparam logic [31:0] DEFAULT_VEC_STRIDE = 32'd4;

    // A single source still needs a one-bit index so ports never collapse to zero width.
    function automatic int idWidth(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: the lowest set request index wins, with a flag
// telling whether any request is present at all.
module irq_prio_enc
    import irq_seq_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = idWidth(N)
) (
    input  logic [N-1:0]  req_i,
    output logic          valid_o,
    output logic [IW-1:0] idx_o
);

    // Scanning downward lets the lowest active index overwrite any higher one.
    always_comb begin
        valid_o = |req_i;
        idx_o   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                idx_o = IW'(i);
            end
        end
    end

endmodule

// File: rtl/irq_sequencer.sv
// Interrupt sequencer beside the M-stage CSR logic: latches request edges as
// pending, masks and prioritises them, and drives the pipeline entry/return sequence.
module irq_sequencer
    import irq_seq_pkg::*;
#(
    parameter int          NUM_SRC    = 4,
    parameter logic [31:0] VEC_BASE   = DEFAULT_VEC_BASE,
    parameter logic [31:0] VEC_STRIDE = DEFAULT_VEC_STRIDE
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_SRC-1:0]           irq_req,
    input  logic                         mask_we,
    input  logic [NUM_SRC-1:0]           mask_wdata,
    input  logic [31:0]                  PCM,
    input  logic                         ValidM,
    input  logic                         returnM,
    output logic                         Int_flush,
    output logic                         Int_sel,
    output logic [31:0]                  PC_Int,
    output logic [31:0]                  returnadress,
    output logic                         int_active,
    output logic [idWidth(NUM_SRC)-1:0]  int_id,
    output logic [NUM_SRC-1:0]           pending,
    output logic [NUM_SRC-1:0]           mask
);

    localparam int IDW = idWidth(NUM_SRC);

    irqState_e          state_q, state_d;
    logic [NUM_SRC-1:0] pending_q, pending_d;
    logic [NUM_SRC-1:0] mask_q;
    logic [NUM_SRC-1:0] irqPrev_q;
    logic [NUM_SRC-1:0] irqRise;
    logic [NUM_SRC-1:0] cand;
    logic [NUM_SRC-1:0] pendClr;
    logic               ie_q;
    logic [31:0]        retAddr_q;
    logic [IDW-1:0]     intId_q;
    logic [IDW-1:0]     winIdx;
    logic               winValid;
    logic               takeEntry;

    assign irqRise = irq_req & ~irqPrev_q;
    assign cand    = pending_q & mask_q;

    irq_prio_enc #(
        .N  (NUM_SRC),
        .IW (IDW)
    ) u_prio (
        .req_i   (cand),
        .valid_o (winValid),
        .idx_o   (winIdx)
    );

    // Entry only on a real instruction in M, and never while a return is retiring.
    assign takeEntry = (state_q == IDLE) && winValid && ie_q && ValidM && !returnM;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (takeEntry) state_d = FLUSH;
            FLUSH:   state_d = VECTOR;
            VECTOR:  state_d = HANDLER;
            HANDLER: if (returnM) state_d = RETURN;
            RETURN:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        Int_flush  = 1'b0;
        Int_sel    = 1'b0;
        PC_Int     = 32'd0;
        int_active = 1'b0;
        case (state_q)
            FLUSH: Int_flush = 1'b1;
            VECTOR: begin
                Int_sel    = 1'b1;
                PC_Int     = VEC_BASE + (32'(intId_q) * VEC_STRIDE);
                int_active = 1'b1;
            end
            HANDLER: int_active = 1'b1;
            RETURN:  int_active = 1'b1;
            default: ;
        endcase
    end

    // The serviced bit drops while vectoring; a fresh edge on that bit still wins.
    always_comb begin
        pendClr = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            pendClr[i] = (state_q == VECTOR) && (intId_q == IDW'(i));
        end
        pending_d = (pending_q & ~pendClr) | irqRise;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            irqPrev_q <= '0;
            pending_q <= '0;
            mask_q    <= '1;
            ie_q      <= 1'b1;
            retAddr_q <= 32'd0;
            intId_q   <= '0;
        end else begin
            irqPrev_q <= irq_req;
            pending_q <= pending_d;
            if (mask_we) begin
                mask_q <= mask_wdata;
            end
            if (takeEntry) begin
                ie_q      <= 1'b0;
                retAddr_q <= PCM;
                intId_q   <= winIdx;
            end else if (state_q == RETURN) begin
                ie_q <= 1'b1;
            end
        end
    end

    assign returnadress = retAddr_q;
    assign int_id       = intId_q;
    assign pending      = pending_q;
    assign mask         = mask_q;

endmodule
